instr_encoder: RTL and testbench

Instruction encoder and program loader for the single-cycle MIPS datapath: the write-side counterpart of the control decoder. It accepts symbolic instruction requests (operation select plus register/immediate/target fields) over a valid/ready handshake. It packs each request into a 32-bit MIPS instruction word using the same opcode map the decoder consumes, and writes the words to consecutive instruction-memory word addresses. Used by benches and the boot path to fill instruction memory before the CPU is released.

---
 rtl/instr_encoder.sv | 173 +++++++++++++++++
 tb/tb_instr_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder and program loader: packs symbolic MIPS instruction requests
// into 32-bit words and writes them to consecutive instruction-memory word addresses.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    input  logic              last_i,
    input  logic              clear_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_ack_i,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o,
    output logic [1:0]        state_o
);

    // Handshakes: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; a memory write completes on a rising edge where
    // mem_we_o and mem_ack_i are both high. Neither side may drop its request early.

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        WRITE  = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

    state_t            state;
    logic              ready_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       data_q;

    logic              op_valid;
    logic [31:0]       enc_word;

    always_comb begin
        op_valid = 1'b1;
        enc_word = '0;
        case (op_sel_i)
            3'd0:    enc_word = {OPC_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            3'd1:    enc_word = {OPC_ADDI, rs_i, rt_i, imm_i};
            3'd2:    enc_word = {OPC_ORI, rs_i, rt_i, imm_i};
            3'd3:    enc_word = {OPC_BEQ, rs_i, rt_i, imm_i};
            3'd4:    enc_word = {OPC_LW, rs_i, rt_i, imm_i};
            3'd5:    enc_word = {OPC_SW, rs_i, rt_i, imm_i};
            3'd6:    enc_word = {OPC_J, target_i};
            default: op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ACCEPT;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (req_valid_i) begin
                        if (op_valid) begin
                            data_q  <= enc_word;
                            last_q  <= last_i;
                            ready_q <= 1'b0;
                            we_q    <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            // Invalid op is swallowed: flag it, write nothing.
                            err_q <= 1'b1;
                            if (last_i) begin
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                                state   <= DONE;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (mem_ack_i) begin
                        we_q    <= 1'b0;
                        count_q <= count_q + COUNT_ONE;
                        // Address saturates at the top word; the load ends there instead.
                        if (addr_q != ADDR_MAX) begin
                            addr_q <= addr_q + ADDR_ONE;
                        end
                        if (last_q || addr_q == ADDR_MAX) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                            if (!last_q) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            ready_q <= 1'b1;
                            state   <= ACCEPT;
                        end
                    end
                end

                DONE: begin
                    if (clear_i) begin
                        ready_q <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        addr_q  <= '0;
                        count_q <= '0;
                        state   <= ACCEPT;
                    end
                end

                default: begin
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= ACCEPT;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign count_o     = count_q;
    assign state_o     = state;

    a_write_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_we_o && !mem_ack_i) |=> (mem_we_o && $stable(mem_data_o) && $stable(mem_addr_o)));

    a_ready_we_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_we_o && req_ready_o));

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_o <= (ADDR_W+1)'(2**ADDR_W));

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written multi-cycle sequences,
// and randomized requests scored against a transaction-level loader model.
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int W      = ADDR_W + 32;
    localparam int NWORDS = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [2:0]        op_sel_i = '0;
    logic [4:0]        rs_i = '0, rt_i = '0, rd_i = '0, shamt_i = '0;
    logic [5:0]        funct_i = '0;
    logic [15:0]       imm_i = '0;
    logic [25:0]       target_i = '0;
    logic              last_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              mem_ack_i = 1'b0;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W:0]   count_o;
    logic [1:0]        state_o;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i), .target_i(target_i),
        .last_i(last_i), .clear_i(clear_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .done_o(done_o), .err_o(err_o),
        .count_o(count_o), .state_o(state_o)
    );

    typedef struct {
        logic        rst_before;
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tg;
        logic        last;
        int          ack_wait;
        logic [31:0] word;
        logic        exp_acc;
        int          exp_count;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    // Loader model state for the random phase
    int   m_addr, m_count;
    logic m_err, m_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed write must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst_i && mem_we_o === 1'b1 && mem_ack_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, want no write",
                         mem_addr_o, mem_data_o);
            end else begin
                check("write_addr_data", 64'({mem_addr_o, mem_data_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic vec_t mk(input logic rb, input logic [2:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [5:0] fn, input logic [15:0] imm,
                                input logic [25:0] tg, input logic last, input int aw,
                                input logic [31:0] word, input logic acc, input int cnt,
                                input logic err, input logic done);
        vec_t v;
        v.rst_before = rb; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
        v.fn = fn; v.imm = imm; v.tg = tg; v.last = last; v.ack_wait = aw;
        v.word = word; v.exp_acc = acc; v.exp_count = cnt; v.exp_err = err;
        v.exp_done = done;
        return v;
    endfunction

    // Reference encoding from the field layout, built with shifts and a lookup table.
    function automatic logic [31:0] ref_encode(input vec_t v);
        int unsigned opc[7] = '{0, 8, 13, 4, 35, 43, 2};
        int unsigned w;
        if (v.op == 3'd6)
            w = (32'd2 << 26) + 32'(v.tg);
        else if (v.op == 3'd0)
            w = (32'(v.rs) << 21) + (32'(v.rt) << 16) + (32'(v.rd) << 11) +
                (32'(v.sh) << 6) + 32'(v.fn);
        else
            w = (opc[v.op] << 26) + (32'(v.rs) << 21) + (32'(v.rt) << 16) + 32'(v.imm);
        return w;
    endfunction

    task automatic drive_fields(input vec_t v);
        op_sel_i = v.op; rs_i = v.rs; rt_i = v.rt; rd_i = v.rd; shamt_i = v.sh;
        funct_i = v.fn; imm_i = v.imm; target_i = v.tg; last_i = v.last;
    endtask

    task automatic do_reset();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        rst_i = 1'b1; req_valid_i = 1'b0; clear_i = 1'b0; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
    endtask

    // Offers one request (bounded wait), then runs its write phase with ack_wait idle cycles.
    task automatic send(input vec_t v, input logic rnd, output logic acc);
        drive_fields(v);
        req_valid_i = 1'b1;
        mem_ack_i   = (v.ack_wait == 0);
        clear_i     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        acc = 1'b0;
        for (int b = 0; b < 4 && !acc; b++) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk); #1;
        end
        req_valid_i = 1'b0;
        clear_i     = 1'b0;
        if (acc && v.op != 3'd7) begin
            for (int i = 0; i < v.ack_wait; i++) begin
                clear_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                check("we_held", 64'(mem_we_o), 64'd1);
                check("data_held", 64'(mem_data_o), 64'(v.word));
                check("ready_low_in_write", 64'(req_ready_o), 64'd0);
                @(posedge clk); #1;
            end
            clear_i   = 1'b0;
            mem_ack_i = 1'b1;
            @(negedge clk);
            check("we_at_ack", 64'(mem_we_o), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic post_check(input string tag, input int cnt, input logic err, input logic done);
        @(negedge clk);
        check({tag, "_count"}, 64'(count_o), 64'(cnt));
        check({tag, "_err"}, 64'(err_o), 64'(err));
        check({tag, "_done"}, 64'(done_o), 64'(done));
        check({tag, "_ready"}, 64'(req_ready_o), 64'(!done));
        check({tag, "_we_idle"}, 64'(mem_we_o), 64'd0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[11];

    initial begin
        vec_t v;
        logic acc;
        int   exp_addr;

        tbl[0]  = mk(1, 3'd1, 1, 2, 0, 0, 6'h00, 16'h0005, 26'h0, 0, 0, 32'h20220005, 1, 1, 0, 0);
        tbl[1]  = mk(1, 3'd0, 3, 4, 5, 0, 6'h20, 16'h0, 26'h0, 0, 0, 32'h00642820, 1, 1, 0, 0);
        tbl[2]  = mk(0, 3'd6, 0, 0, 0, 0, 6'h00, 16'h0, 26'h10, 1, 0, 32'h08000010, 1, 2, 0, 1);
        tbl[3]  = mk(1, 3'd4, 29, 8, 0, 0, 6'h00, 16'hFFFC, 26'h0, 0, 3, 32'h8FA8FFFC, 1, 1, 0, 0);
        tbl[4]  = mk(1, 3'd7, 7, 7, 7, 7, 6'h3F, 16'h1234, 26'h0, 0, 0, 32'h0, 1, 0, 1, 0);
        tbl[5]  = mk(0, 3'd2, 0, 9, 0, 0, 6'h00, 16'h00FF, 26'h0, 0, 1, 32'h340900FF, 1, 1, 1, 0);
        tbl[6]  = mk(1, 3'd5, 2, 3, 0, 0, 6'h00, 16'h0010, 26'h0, 0, 0, 32'hAC430010, 1, 1, 0, 0);
        tbl[7]  = mk(0, 3'd3, 31, 31, 0, 0, 6'h00, 16'hFFFF, 26'h0, 0, 2, 32'h13FFFFFF, 1, 2, 0, 0);
        tbl[8]  = mk(0, 3'd0, 0, 1, 31, 31, 6'h3F, 16'h0, 26'h0, 0, 0, 32'h0001FFFF, 1, 3, 0, 0);
        tbl[9]  = mk(0, 3'd6, 0, 0, 0, 0, 6'h00, 16'h0, 26'h3FFFFFF, 0, 0, 32'h0BFFFFFF, 1, 4, 1, 1);
        tbl[10] = mk(0, 3'd1, 1, 1, 0, 0, 6'h00, 16'h0001, 26'h0, 0, 0, 32'h0, 0, 4, 1, 1);

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_we", 64'(mem_we_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_data", 64'(mem_data_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        @(posedge clk); #1;

        // Directed vector table
        exp_addr = 0;
        for (int i = 0; i < 11; i++) begin
            v = tbl[i];
            if (v.rst_before) begin
                do_reset();
                exp_addr = 0;
            end
            if (v.exp_acc && v.op != 3'd7) begin
                exp_q.push_back({2'(exp_addr), v.word});
                exp_addr++;
            end
            send(v, 1'b0, acc);
            check($sformatf("vec%0d_accepted", i), 64'(acc), 64'(v.exp_acc));
            post_check($sformatf("vec%0d", i), v.exp_count, v.exp_err, v.exp_done);
        end

        // clear_i from DONE after overflow
        clear_i = 1'b1;
        @(negedge clk);
        check("clear_pending_done", 64'(done_o), 64'd1);
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        check("clear_addr", 64'(mem_addr_o), 64'd0);
        @(posedge clk); #1;
        post_check("clear", 0, 1'b0, 1'b0);
        v = mk(0, 3'd1, 4, 5, 0, 0, 6'h00, 16'h8000, 26'h0, 1, 0, 32'h20858000, 1, 1, 0, 1);
        exp_q.push_back({2'd0, v.word});
        send(v, 1'b0, acc);
        check("after_clear_accepted", 64'(acc), 64'd1);
        post_check("after_clear", 1, 1'b0, 1'b1);

        // Reset pulsed during a stalled write
        do_reset();
        v = mk(0, 3'd4, 29, 8, 0, 0, 6'h00, 16'hFFFC, 26'h0, 0, 9, 32'h8FA8FFFC, 1, 0, 0, 0);
        drive_fields(v);
        req_valid_i = 1'b1;
        mem_ack_i   = 1'b0;
        @(negedge clk);
        check("midrst_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("midrst_we_before", 64'(mem_we_o), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midrst_we_after", 64'(mem_we_o), 64'd0);
        check("midrst_addr", 64'(mem_addr_o), 64'd0);
        check("midrst_data", 64'(mem_data_o), 64'd0);
        @(posedge clk); #1;
        post_check("midrst", 0, 1'b0, 1'b0);
        mem_ack_i = 1'b1;
        v = mk(0, 3'd2, 0, 9, 0, 0, 6'h00, 16'h00FF, 26'h0, 0, 0, 32'h340900FF, 1, 1, 0, 0);
        exp_q.push_back({2'd0, v.word});
        send(v, 1'b0, acc);
        check("midrst_next_accepted", 64'(acc), 64'd1);
        post_check("midrst_next", 1, 1'b0, 1'b0);

        // Randomized requests against the loader model
        do_reset();
        m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (m_done) begin
                clear_i = 1'b1;
                @(posedge clk); #1;
                clear_i = 1'b0;
                m_addr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
            end
            v = mk(0, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 2), 32'h0, 1, 0, 0, 0);
            v.word = ref_encode(v);
            if (v.op == 3'd7) begin
                m_err = 1'b1;
                if (v.last) m_done = 1'b1;
            end else begin
                exp_q.push_back({2'(m_addr), v.word});
                m_count++;
                if (v.last || m_addr == NWORDS - 1) m_done = 1'b1;
                if (!v.last && m_addr == NWORDS - 1) m_err = 1'b1;
                m_addr++;
            end
            send(v, 1'b1, acc);
            check("rnd_accepted", 64'(acc), 64'd1);
            post_check("rnd", m_count, m_err, m_done);
        end

        check("final_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
